cam_table: RTL

//  Parametrised content-addressable table of DEPTH entries, WIDTH bits each, with per-entry valid bits.

---
 rtl/cam_table.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cam_table.sv
// cam_table: content-addressable key table with per-entry valid bits.
// Insert (dedup / lowest free / round-robin victim), invalidate, registered search.
module cam_table #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_key_i,
    input  logic             inv_en_i,
    input  logic [IDX_W-1:0] inv_idx_i,
    input  logic             srch_en_i,
    input  logic [WIDTH-1:0] srch_key_i,
    output logic             match_vld_o,
    output logic             match_o,
    output logic [DEPTH-1:0] match_vec_o,
    output logic [IDX_W-1:0] match_idx_o,
    output logic [IDX_W-1:0] wr_idx_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);

    logic [WIDTH-1:0] r_key [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [IDX_W-1:0] r_victim;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_match_vld;
    logic             r_match;
    logic [DEPTH-1:0] r_match_vec;
    logic [IDX_W-1:0] r_match_idx;
    logic [IDX_W-1:0] r_wr_idx;

    logic [DEPTH-1:0] w_srch_vec;
    logic [IDX_W-1:0] w_srch_idx;
    logic [DEPTH-1:0] w_wr_hit;
    logic [IDX_W-1:0] w_wr_hit_idx;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_wr_hit_any;
    logic             w_free_any;
    logic [IDX_W-1:0] w_wr_tgt;
    logic             w_wr_store;
    logic             w_evict;
    logic [DEPTH-1:0] w_valid_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Per-entry compare of both keys against pre-edge valid contents
    always_comb begin
        w_srch_vec = '0;
        w_wr_hit   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_srch_vec[i] = r_valid[i] && (r_key[i] == srch_key_i);
            w_wr_hit[i]   = r_valid[i] && (r_key[i] == wr_key_i);
        end
    end

    // Lowest-index priority encoders for search hit, insert hit and free slot
    always_comb begin
        w_srch_idx   = '0;
        w_wr_hit_idx = '0;
        w_free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_srch_vec[i]) w_srch_idx = IDX_W'(i);
            if (w_wr_hit[i])   w_wr_hit_idx = IDX_W'(i);
            if (!r_valid[i])   w_free_idx = IDX_W'(i);
        end
    end

    assign w_wr_hit_any = |w_wr_hit;
    assign w_free_any   = ~&r_valid;

    // Insert target: existing copy, else lowest free entry, else victim
    always_comb begin
        w_wr_tgt = r_victim;
        if (w_wr_hit_any)    w_wr_tgt = w_wr_hit_idx;
        else if (w_free_any) w_wr_tgt = w_free_idx;
    end

    assign w_wr_store = wr_en_i && !w_wr_hit_any;
    assign w_evict    = w_wr_store && !w_free_any;

    // Next valid bits: invalidate first, insert sets last so it wins a tie
    always_comb begin
        w_valid_nxt = r_valid;
        if (inv_en_i) w_valid_nxt[inv_idx_i] = 1'b0;
        if (wr_en_i)  w_valid_nxt[w_wr_tgt] = 1'b1;
    end

    // Population count of the next valid vector
    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + CNT_W'(w_valid_nxt[i]);
        end
    end

    // Table storage, victim pointer and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_key[i] <= '0;
            r_valid  <= '0;
            r_victim <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_wr_idx <= '0;
        end else begin
            if (w_wr_store) r_key[w_wr_tgt] <= wr_key_i;
            if (w_evict)    r_victim <= r_victim + IDX_W'(1);
            if (wr_en_i)    r_wr_idx <= w_wr_tgt;
            r_valid <= w_valid_nxt;
            r_count <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
        end
    end

    // Registered search result, held between searches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match_vld <= 1'b0;
            r_match     <= 1'b0;
            r_match_vec <= '0;
            r_match_idx <= '0;
        end else begin
            r_match_vld <= srch_en_i;
            if (srch_en_i) begin
                r_match     <= |w_srch_vec;
                r_match_vec <= w_srch_vec;
                r_match_idx <= w_srch_idx;
            end
        end
    end

    assign match_vld_o = r_match_vld;
    assign match_o     = r_match;
    assign match_vec_o = r_match_vec;
    assign match_idx_o = r_match_idx;
    assign wr_idx_o    = r_wr_idx;
    assign count_o     = r_count;
    assign full_o      = r_full;

endmodule
